bcd_isqrt_seq: RTL and testbench

//  Iterative digit-recurrence BCD integer square-root core for the decimal-float sqrt datapath.

---
 rtl/bcd_isqrt_seq_pkg.sv | 11 +
 rtl/bcd_isqrt_seq_addsub.sv | 38 +++
 rtl/bcd_isqrt_seq.sv | 147 ++++++++++++++
 tb/tb_bcd_isqrt_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_isqrt_seq_pkg.sv
// Shared BCD types for the decimal-float sqrt datapath.
// Holds the digit type and constants used by the BCD square-root core.
package bcd_isqrt_seq_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'h9;
    localparam bcd_digit_t BCD_ONE  = 4'h1;
    localparam bcd_digit_t BCD_TWO  = 4'h2;

endpackage

// File: rtl/bcd_isqrt_seq_addsub.sv
// bcd_addsub_n: combinational D-digit BCD adder/subtractor.
// Subtraction uses the 9's complement of i_b with carry-in 1; o_co=1 means no borrow.
module bcd_addsub_n
    import bcd_isqrt_seq_pkg::*;
#(
    parameter int D = 4
) (
    input  logic [4*D-1:0] i_a,
    input  logic [4*D-1:0] i_b,
    input  logic           i_sub,
    output logic [4*D-1:0] o_sum,
    output logic           o_co
);

    always_comb begin
        logic       w_c;
        logic [4:0] w_s;
        bcd_digit_t w_bd;
        // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
        o_sum = '0;
        w_c   = i_sub;
        w_s   = '0;
        w_bd  = '0;
        for (int i = 0; i < D; i++) begin
            w_bd = i_sub ? (BCD_NINE - i_b[4*i +: 4]) : i_b[4*i +: 4];
            w_s  = {1'b0, i_a[4*i +: 4]} + {1'b0, w_bd} + {4'b0000, w_c};
            if (w_s > 5'd9) begin
                w_s = w_s + 5'd6;
                w_c = 1'b1;
            end else begin
                w_c = 1'b0;
            end
            o_sum[4*i +: 4] = w_s[3:0];
        end
        o_co = w_c;
    end

endmodule

// File: rtl/bcd_isqrt_seq.sv
// bcd_isqrt_seq: digit-recurrence BCD integer square root, one compare-subtract per cycle.
// Optional build macro BCD_ISQRT_EARLY_EXIT_EN skips trailing all-zero pairs once the remainder is zero.
module bcd_isqrt_seq
    import bcd_isqrt_seq_pkg::*;
#(
    parameter int N = 26
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           ld,
    input  logic [8*N-1:0] a,
    output logic [4*N-1:0] o,
    output logic           sticky,
    output logic           busy,
    output logic           done
);

    localparam int RD = N + 2;
    localparam int KW = $clog2(N + 1);
    localparam logic [4*RD-1:0] TWO = {{(4*RD-4){1'b0}}, BCD_TWO};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SUB, S_DONE} state_t;

    state_t          r_state;
    logic [4*RD-1:0] r_r;
    logic [4*RD-1:0] r_t;
    logic [4*N-1:0]  r_q;
    bcd_digit_t      r_d;
    logic [KW-1:0]   r_k;
    logic [8*N-1:0]  r_a;
    logic [4*N-1:0]  r_o;
    logic            r_sticky;
    logic            r_busy;
    logic            r_done;

    logic [4*RD-1:0] w_diff;
    logic            w_no_borrow;
    logic [4*RD-1:0] w_t_inc;
    logic            w_inc_unused;
    logic [4*N-1:0]  w_q2;
    logic            w_q2_co;
    logic [7:0]      w_pair;
    logic            w_exit;
    logic [4*N-1:0]  w_q_fill;

    bcd_addsub_n #(.D(RD)) u_sub (.i_a(r_r), .i_b(r_t), .i_sub(1'b1), .o_sum(w_diff), .o_co(w_no_borrow));
    bcd_addsub_n #(.D(RD)) u_inc (.i_a(r_t), .i_b(TWO), .i_sub(1'b0), .o_sum(w_t_inc), .o_co(w_inc_unused));
    bcd_addsub_n #(.D(N))  u_dbl (.i_a(r_q), .i_b(r_q), .i_sub(1'b0), .o_sum(w_q2), .o_co(w_q2_co));

    // 20Q+1 is 2Q shifted up one digit with a units digit of 1.
    wire [4*RD-1:0]  w_t_init  = {3'b000, w_q2_co, w_q2, BCD_ONE};
    wire [4*RD-1:0]  w_r_shift = {r_r[4*N-1:0], w_pair};
    wire bcd_digit_t w_digit   = r_d + {3'b000, w_no_borrow};
    wire [4*N-1:0]   w_q_next  = {r_q[4*N-5:0], w_digit};
    wire [4*RD-1:0]  w_r_sub   = w_no_borrow ? w_diff : r_r;

    always_comb begin
        w_pair = '0;
        for (int i = 0; i < N; i++)
            if (r_k == KW'(i)) w_pair = r_a[8*(N-1-i) +: 8];
    end

`ifdef BCD_ISQRT_EARLY_EXIT_EN
    always_comb begin
        w_exit = (r_r == '0);
        for (int i = 0; i < N; i++)
            if (KW'(i) >= r_k && r_a[8*(N-1-i) +: 8] != 8'h00) w_exit = 1'b0;
        w_q_fill = r_q << (4 * (N - int'(r_k)));
    end
`else
    assign w_exit   = 1'b0;
    assign w_q_fill = r_q;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_r      <= '0;
            r_t      <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_k      <= '0;
            r_a      <= '0;
            r_o      <= '0;
            r_sticky <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (ce) begin
            if (ld) begin
                r_a     <= a;
                r_r     <= '0;
                r_q     <= '0;
                r_k     <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_state <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (w_exit) begin
                            r_o      <= w_q_fill;
                            r_sticky <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_r     <= w_r_shift;
                            r_t     <= w_t_init;
                            r_d     <= '0;
                            r_k     <= r_k + KW'(1);
                            r_state <= S_SUB;
                        end
                    end
                    S_SUB: begin
                        if (w_no_borrow && r_d < BCD_NINE) begin
                            r_r <= w_diff;
                            r_t <= w_t_inc;
                            r_d <= r_d + 4'd1;
                        end else begin
                            // Digit settles: keep the last good remainder and append the digit.
                            r_r <= w_r_sub;
                            r_q <= w_q_next;
                            if (r_k == KW'(N)) begin
                                r_o      <= w_q_next;
                                r_sticky <= (w_r_sub != '0);
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state <= S_SHIFT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o      = r_o;
    assign sticky = r_sticky;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_bcd_isqrt_seq.sv
// Scoreboard bench for bcd_isqrt_seq: N=4 instance (directed, random, ce stalls, resets)
// and N=26 instance (random 52-digit radicands) against a binary-arithmetic reference model.
module tb_bcd_isqrt_seq;

    localparam int NS = 4;
    localparam int NL = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ce, ld, ld26;
    logic [31:0]   a;
    logic [207:0]  a26;
    logic [15:0]   o;
    logic          sticky, busy, done;
    logic [103:0]  o26;
    logic          sticky26, busy26, done26;

    bcd_isqrt_seq #(.N(NS)) u_dut4 (
        .clk(clk), .rst(rst), .ce(ce), .ld(ld), .a(a),
        .o(o), .sticky(sticky), .busy(busy), .done(done)
    );

    bcd_isqrt_seq #(.N(NL)) u_dut26 (
        .clk(clk), .rst(rst), .ce(ce), .ld(ld26), .a(a26),
        .o(o26), .sticky(sticky26), .busy(busy26), .done(done26)
    );

    typedef struct { logic [15:0] o; logic stk; int lat; } exp_s_t;
    typedef struct { logic [103:0] o; logic stk; } exp_l_t;

    exp_s_t sb_s[$];
    exp_l_t sb_l[$];
    exp_s_t e_s;
    exp_l_t e_l;

    int     n_tests = 0;
    int     n_fail  = 0;
    bit     rand_ce = 1'b0;
    int     act_cnt = 0;
    int     start_cnt = 0;
    logic   done_prev = 1'b0;
    logic   done26_prev = 1'b0;
    logic [15:0] last_o = '0;

    task automatic check(input bit ok, input string name, input logic [207:0] act, input logic [207:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: convert BCD to binary, take floor sqrt bit by bit, convert back.
    function automatic void model(input logic [207:0] x, input int nd, output logic [103:0] root, output logic stk);
        logic [175:0] v, r, cand;
        logic [3:0]   dg;
        v = '0;
        for (int i = 2*nd-1; i >= 0; i--) begin
            dg = x[4*i +: 4];
            v  = v * 176'd10 + {172'd0, dg};
        end
        r = '0;
        for (int b = 87; b >= 0; b--) begin
            cand = r | (176'd1 << b);
            if (cand * cand <= v) r = cand;
        end
        stk  = (v != r * r);
        root = '0;
        for (int i = 0; i < nd; i++) begin
            root[4*i +: 4] = 4'(r % 176'd10);
            r = r / 176'd10;
        end
    endfunction

    function automatic longint isqrt_small(input longint v);
        longint r, c;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= v) r = c;
        end
        return r;
    endfunction

    function automatic longint bcd2bin(input logic [31:0] x);
        longint v;
        v = 0;
        for (int i = 7; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
        return v;
    endfunction

    // Cycles from ld to done: each root digit d costs d+2 (one shift, d good trials, one failing trial).
    function automatic int lat4(input logic [31:0] x);
        int     lat;
        longint p, q, qn;
`ifdef BCD_ISQRT_EARLY_EXIT_EN
        logic [31:0] rest;
`endif
        lat = 0;
        for (int i = 0; i < NS; i++) begin
            p = bcd2bin(x >> (8*(NS-i)));
            q = isqrt_small(p);
`ifdef BCD_ISQRT_EARLY_EXIT_EN
            rest = x << (8*i);
            if (p == q*q && rest == 32'd0) return lat + 1;
`endif
            qn  = isqrt_small(bcd2bin(x >> (8*(NS-1-i))));
            lat += int'(qn - 10*q) + 2;
        end
        return lat;
    endfunction

    function automatic logic [31:0] rand_bcd8();
        logic [31:0] r;
        int nz;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        nz = $urandom_range(0, 8);
        for (int i = 8 - nz; i < 8; i++) r[4*i +: 4] = 4'h0;
        return r;
    endfunction

    task automatic push_s(input logic [15:0] eo, input logic es, input int el);
        exp_s_t e;
        e.o = eo; e.stk = es; e.lat = el;
        sb_s.push_back(e);
    endtask

    task automatic push_model(input logic [31:0] x);
        logic [103:0] root;
        logic         stk;
        model({176'd0, x}, NS, root, stk);
        push_s(root[15:0], stk, lat4(x));
    endtask

    task automatic launch4(input logic [31:0] x);
        @(negedge clk);
        a  = x;
        ld = 1'b1;
        do @(posedge clk); while (!ce);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(i < budget, {nm, " timeout"}, 208'(i), 208'(budget));
    endtask

    task automatic check_reset(input string nm);
        check(o == 16'h0,    {nm, " o"},      208'(o), 208'd0);
        check(sticky == 1'b0, {nm, " sticky"}, 208'(sticky), 208'd0);
        check(busy == 1'b0,  {nm, " busy"},   208'(busy), 208'd0);
        check(done == 1'b0,  {nm, " done"},   208'(done), 208'd0);
    endtask

    always @(negedge clk) if (rand_ce) ce = ($urandom_range(0, 1) == 1);

    // Counts enabled edges so latency is measured in ce-qualified cycles.
    always @(posedge clk) begin
        if (!rst) begin
            act_cnt = 0;
            last_o  = '0;
        end else if (ce) begin
            act_cnt++;
            if (ld) start_cnt = act_cnt;
        end
    end

    always @(negedge clk) begin
        if (done && !done_prev) begin
            check(sb_s.size() != 0, "unexpected done", 208'(o), 208'd0);
            if (sb_s.size() != 0) begin
                e_s = sb_s.pop_front();
                check(o == e_s.o,                     "root4",    208'(o), 208'(e_s.o));
                check(sticky == e_s.stk,              "sticky4",  208'(sticky), 208'(e_s.stk));
                check(act_cnt - start_cnt == e_s.lat, "latency4", 208'(act_cnt - start_cnt), 208'(e_s.lat));
                last_o = e_s.o;
            end
        end
        if (busy) check(o == last_o, "o hold", 208'(o), 208'(last_o));
        check(!(busy && done), "busy/done overlap4", 208'({busy, done}), 208'd0);
        done_prev = done;

        if (done26 && !done26_prev) begin
            check(sb_l.size() != 0, "unexpected done26", 208'(o26), 208'd0);
            if (sb_l.size() != 0) begin
                e_l = sb_l.pop_front();
                check(o26 == e_l.o,        "root26",   208'(o26), 208'(e_l.o));
                check(sticky26 == e_l.stk, "sticky26", 208'(sticky26), 208'(e_l.stk));
            end
        end
        check(!(busy26 && done26), "busy/done overlap26", 208'({busy26, done26}), 208'd0);
        done26_prev = done26;
    end

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  x;
        logic [207:0] y;
        logic [103:0] root;
        logic         stk;
        int           nz;

        rst = 1'b0; ce = 1'b1; ld = 1'b0; ld26 = 1'b0; a = '0; a26 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        push_s(16'h0009, 1'b0, 17);
        launch4(32'h0000_0081);
        wait_done("a=81", 200);
        push_s(16'h0001, 1'b1, lat4(32'h2));
        launch4(32'h0000_0002);
        wait_done("a=2", 200);
        push_s(16'h9999, 1'b1, 44);
        launch4(32'h9999_9999);
        wait_done("a=99999999", 200);
`ifdef BCD_ISQRT_EARLY_EXIT_EN
        push_s(16'h1000, 1'b0, 4);
`else
        push_s(16'h1000, 1'b0, 9);
`endif
        launch4(32'h0100_0000);
        wait_done("a=01000000", 200);

        // Abort: second ld lands five cycles after the first; the first result must never appear.
`ifdef BCD_ISQRT_EARLY_EXIT_EN
        launch4(32'h9999_9999);
`else
        launch4(32'h0000_0000);
`endif
        repeat (3) @(negedge clk);
        check(busy == 1'b1, "abort busy", 208'(busy), 208'd1);
        check(done == 1'b0, "abort done", 208'(done), 208'd0);
        push_s(16'h0012, 1'b0, lat4(32'h144));
        launch4(32'h0000_0144);
        wait_done("abort restart", 200);

        // ld together with reset: reset wins, nothing starts.
        @(negedge clk);
        rst = 1'b0; ld = 1'b1; a = 32'h81;
        @(negedge clk);
        rst = 1'b1; ld = 1'b0;
        check_reset("rst+ld");
        @(negedge clk);
        check(busy == 1'b0, "rst+ld no start", 208'(busy), 208'd0);

        for (int i = 0; i < 20; i++) begin
            x = rand_bcd8();
            push_model(x);
            launch4(x);
            wait_done("random", 200);
        end

        rand_ce = 1'b1;
        push_s(16'h0009, 1'b0, 17);
        launch4(32'h0000_0081);
        wait_done("ce a=81", 2000);
        for (int i = 0; i < 10; i++) begin
            x = rand_bcd8();
            push_model(x);
            launch4(x);
            wait_done("ce random", 2000);
        end

        // Mid-operation reset with ce low: reset still takes effect.
        push_s(16'h9999, 1'b1, 44);
        launch4(32'h9999_9999);
        repeat (10) @(negedge clk);
        rand_ce = 1'b0;
        ce  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid-op reset");
        sb_s.delete();
        rst = 1'b1;
        ce  = 1'b1;
        push_s(16'h9999, 1'b1, 44);
        launch4(32'h9999_9999);
        wait_done("after reset", 200);

        for (int t = 0; t < 6; t++) begin
            y = '0;
            for (int i = 0; i < 2*NL; i++) y[4*i +: 4] = 4'($urandom_range(0, 9));
            nz = (t % 2 == 0) ? 0 : $urandom_range(1, 2*NL-1);
            for (int i = 2*NL - nz; i < 2*NL; i++) y[4*i +: 4] = 4'h0;
            model(y, NL, root, stk);
            e_l.o = root; e_l.stk = stk;
            sb_l.push_back(e_l);
            @(negedge clk);
            a26  = y;
            ld26 = 1'b1;
            @(negedge clk);
            ld26 = 1'b0;
            for (nz = 0; nz < 400; nz++) begin
                @(negedge clk);
                if (done26) break;
            end
            check(nz < 400, "n26 timeout", 208'(nz), 208'd400);
        end

        repeat (3) @(negedge clk);
        check(sb_s.size() == 0, "sb4 drained", 208'(sb_s.size()), 208'd0);
        check(sb_l.size() == 0, "sb26 drained", 208'(sb_l.size()), 208'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
